mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port backing memory between the IF fetch port and the MEM-stage load/store port of the pipelined core.
- Arbitrates between the two ports with anti-starvation, and sequences the memory request/grant/response handshake.
- Drives the per-port stall signals consumed by hazard control.
- Discards fetch responses cancelled by a branch-mispredict flush.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive D grants allowed while i_req is pending before I is forced
TIMEOUT, 255, max cycles in a WAIT state before abort; counter width is clog2(TIMEOUT+1)

Ports:
clk  in  1  clock (single clock domain)
rst  in  1  reset, asynchronous, active-high
i_req  in  1  fetch request; held until i_valid or i_flush
i_addr  in  ADDR_W  fetch address
i_flush  in  1  cancel the current/outstanding fetch (mispredict)
i_rdata  out  DATA_W  fetch data
i_valid  out  1  fetch complete, 1-cycle pulse
i_stall  out  1  i_req & ~i_valid
d_req  in  1  load/store request; held until d_valid or d_err
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_u_b_h_w  in  3  funct3 size/sign code
d_rdata  out  DATA_W  load data
d_valid  out  1  load/store complete, 1-cycle pulse
d_err  out  1  timeout abort, 1-cycle pulse
d_stall  out  1  d_req & ~d_valid & ~d_err
m_req  out  1  memory request, held until m_gnt
m_we  out  1  memory write
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_u_b_h_w  out  3  memory size code
m_gnt  in  1  memory accepted request this cycle
m_rvalid  in  1  response/ack, at least 1 cycle after m_gnt
m_rdata  in  DATA_W  response data

Behaviour:
- Reset values:
  - State IDLE.
  - All m_* outputs 0; i_valid, d_valid, d_err 0.
  - starve_cnt and timeout counter 0; latched address, data and size registers 0.
- Reset mid-transaction returns to IDLE immediately. The memory side is re-initialised by the same reset.
- States: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D, DRAIN.
- IDLE arbitration, registered:
  - d_req only → REQ_D.
  - i_req only and ~i_flush → REQ_I.
  - Both: D wins unless starve_cnt == STARVE_LIMIT, in which case I wins.
  - On entry to REQ_x, latch addr/we/wdata/size from that port. Later changes on the port inputs are ignored until completion.
- starve_cnt:
  - +1 on each D grant while i_req is high, saturating at STARVE_LIMIT.
  - Cleared on each I grant, and whenever i_req is low in IDLE.
- m_req = (state == REQ_I | REQ_D). m_we is forced 0 in REQ_I. m_addr, m_wdata, m_we and m_u_b_h_w come from the latched registers.
- REQ_x & m_gnt → WAIT_x. No timeout is applied in REQ states.
- WAIT_I & m_rvalid:
  - i_valid = 1 and i_rdata = m_rdata, combinational pass-through.
  - Next state IDLE.
- WAIT_D & m_rvalid: d_valid = 1 and d_rdata = m_rdata, for loads and store acks alike. Next state IDLE.
- Fetch flush:
  - i_flush in REQ_I: the request stays asserted (m_req must not be withdrawn). After m_gnt go to DRAIN.
  - i_flush in WAIT_I → DRAIN.
  - DRAIN & m_rvalid → IDLE, with no i_valid pulse. i_valid is suppressed in any cycle in which i_flush is high.
  - i_flush in IDLE or in any D state has no effect.
- Timeout:
  - The counter resets on entry to WAIT_x/DRAIN and increments each cycle while m_rvalid is low.
  - Reaching TIMEOUT → IDLE. In WAIT_D this also pulses d_err. In WAIT_I or DRAIN it drops silently, and the requester re-requests.
- One transaction is outstanding at a time. No pipelining of requests.
- Minimum latency, req to valid, is 3 cycles:
  - c0: req seen in IDLE.
  - c1: m_req, m_gnt.
  - c2: m_rvalid, valid.
- A new arbitration happens in the cycle after completion. There is no back-to-back bypass.

Test Plan:
1. i_req only, i_addr=0x40; m_gnt same cycle; m_rvalid 1 cycle later with m_rdata=0x00000013 → m_req in c1 with m_addr=0x40, m_we=0; i_valid and i_rdata=0x13 in c2; i_stall low in c3.
2. d_req store (we=1, addr=0x100, wdata=0xDEADBEEF, u_b_h_w=3'b010) together with i_req → D granted first with m_we=1 and m_wdata=0xDEADBEEF; I granted after d_valid.
3. d_req held continuously with i_req high and STARVE_LIMIT=4 → 4 D transactions, 5th grant goes to I, starve_cnt then 0.
4. Fetch granted, i_flush pulsed in WAIT_I, m_rvalid 3 cycles later → no i_valid; new i_req granted in the cycle after DRAIN exits.
5. d_req load, m_rvalid never asserted, TIMEOUT=255 → d_err pulse exactly 255 cycles after WAIT_D entry; state IDLE; d_valid never asserted.
6. rst asserted asynchronously mid-WAIT_D → m_req, d_valid and d_err fall immediately with no clock edge; state IDLE after rst deasserts.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and backing-memory handshake bundle.
// Revision    : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;
    logic              i_stall;
    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_u_b_h_w;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_err;
    logic              d_stall;
    // Backing memory
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [2:0]        m_u_b_h_w;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, i_flush,
        output i_rdata, i_valid, i_stall,
        input  d_req, d_we, d_addr, d_wdata, d_u_b_h_w,
        output d_rdata, d_valid, d_err, d_stall,
        output m_req, m_we, m_addr, m_wdata, m_u_b_h_w,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport master (
        output i_req, i_addr, i_flush,
        input  i_rdata, i_valid, i_stall,
        output d_req, d_we, d_addr, d_wdata, d_u_b_h_w,
        input  d_rdata, d_valid, d_err, d_stall,
        input  m_req, m_we, m_addr, m_wdata, m_u_b_h_w,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between fetch and load/store
//               ports with anti-starvation, flush draining and timeout abort.
// Revision    : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_port_arbiter_if.slave bus_io
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [TMO_W-1:0] C_TMO_MAX = TMO_W'(TIMEOUT);
    localparam logic [STV_W-1:0] C_STV_MAX = STV_W'(STARVE_LIMIT);
    localparam logic [2:0]       C_SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ_I  = 3'd1,
        S_REQ_D  = 3'd2,
        S_WAIT_I = 3'd3,
        S_WAIT_D = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t            state_q,  state_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [TMO_W-1:0]  tmo_q,    tmo_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              we_q,     we_d;
    logic [2:0]        size_q,   size_d;
    logic              flush_q,  flush_d;

    logic w_i_ok;
    logic w_tmo_hit;
    logic w_waiting;

    assign w_i_ok    = bus_io.i_req & ~bus_io.i_flush;
    assign w_tmo_hit = (tmo_q == C_TMO_MAX);
    assign w_waiting = (state_q == S_WAIT_I) || (state_q == S_WAIT_D) ||
                       (state_q == S_DRAIN);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        size_d   = size_q;
        flush_d  = flush_q;

        if (w_waiting && !bus_io.m_rvalid) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!bus_io.i_req) begin
                    starve_d = '0;
                end
                // D wins ties until the fetch port has been passed over STARVE_LIMIT times
                if (bus_io.d_req && (!w_i_ok || (starve_q != C_STV_MAX))) begin
                    state_d = S_REQ_D;
                    addr_d  = bus_io.d_addr;
                    wdata_d = bus_io.d_wdata;
                    we_d    = bus_io.d_we;
                    size_d  = bus_io.d_u_b_h_w;
                    if (bus_io.i_req && (starve_q != C_STV_MAX)) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                end else if (w_i_ok) begin
                    state_d  = S_REQ_I;
                    addr_d   = bus_io.i_addr;
                    we_d     = 1'b0;
                    size_d   = C_SIZE_WORD;
                    starve_d = '0;
                    flush_d  = 1'b0;
                end
            end
            S_REQ_I: begin
                // A flush here cannot withdraw m_req; remember it until the grant
                if (bus_io.i_flush) begin
                    flush_d = 1'b1;
                end
                if (bus_io.m_gnt) begin
                    state_d = (flush_q || bus_io.i_flush) ? S_DRAIN : S_WAIT_I;
                    tmo_d   = '0;
                end
            end
            S_REQ_D: begin
                if (bus_io.m_gnt) begin
                    state_d = S_WAIT_D;
                    tmo_d   = '0;
                end
            end
            S_WAIT_I: begin
                if (bus_io.m_rvalid) begin
                    state_d = S_IDLE;
                end else if (bus_io.i_flush) begin
                    state_d = S_DRAIN;
                    tmo_d   = '0;
                end else if (w_tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_D, S_DRAIN: begin
                if (bus_io.m_rvalid || w_tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            tmo_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            size_q   <= 3'b000;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            size_q   <= size_d;
            flush_q  <= flush_d;
        end
    end

    // Memory side is driven purely from latched state, so port input changes are ignored
    assign bus_io.m_req     = (state_q == S_REQ_I) || (state_q == S_REQ_D);
    assign bus_io.m_we      = we_q;
    assign bus_io.m_addr    = addr_q;
    assign bus_io.m_wdata   = wdata_q;
    assign bus_io.m_u_b_h_w = size_q;

    assign bus_io.i_rdata = bus_io.m_rdata;
    assign bus_io.i_valid = (state_q == S_WAIT_I) & bus_io.m_rvalid & ~bus_io.i_flush;
    assign bus_io.i_stall = bus_io.i_req & ~bus_io.i_valid;

    assign bus_io.d_rdata = bus_io.m_rdata;
    assign bus_io.d_valid = (state_q == S_WAIT_D) & bus_io.m_rvalid;
    assign bus_io.d_err   = (state_q == S_WAIT_D) & ~bus_io.m_rvalid & w_tmo_hit;
    assign bus_io.d_stall = bus_io.d_req & ~bus_io.d_valid & ~bus_io.d_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(255)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic early;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.i_req = 0; bus.i_addr = '0; bus.i_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_u_b_h_w = '0;
        bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = '0;

        cyc(); cyc();
        chk("rst_m_req", bus.m_req, 0);
        chk("rst_m_we", bus.m_we, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_m_size", bus.m_u_b_h_w, 0);
        chk("rst_valids", {bus.i_valid, bus.d_valid, bus.d_err}, 0);
        rst = 1'b0;

        // 1: single fetch, minimum latency
        cyc(); bus.i_req = 1; bus.i_addr = 32'h40;
        #1; chk("t1_c0_m_req", bus.m_req, 0); chk("t1_c0_stall", bus.i_stall, 1);
        cyc(); bus.m_gnt = 1;
        #1; chk("t1_c1_m_req", bus.m_req, 1); chk("t1_c1_addr", bus.m_addr, 32'h40);
        chk("t1_c1_we", bus.m_we, 0);
        cyc(); bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h13;
        #1; chk("t1_c2_ivalid", bus.i_valid, 1); chk("t1_c2_rdata", bus.i_rdata, 32'h13);
        chk("t1_c2_stall", bus.i_stall, 0);
        cyc(); bus.m_rvalid = 0; bus.i_req = 0;
        #1; chk("t1_c3_ivalid", bus.i_valid, 0); chk("t1_c3_stall", bus.i_stall, 0);

        // 2: store and fetch together, D first, then I
        cyc(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
        bus.d_u_b_h_w = 3'b010; bus.i_req = 1; bus.i_addr = 32'h80;
        cyc(); bus.m_gnt = 1; bus.d_addr = 32'h999; bus.d_wdata = 32'h0;
        #1; chk("t2_m_req", bus.m_req, 1); chk("t2_we", bus.m_we, 1);
        chk("t2_addr", bus.m_addr, 32'h100); chk("t2_wdata", bus.m_wdata, 32'hDEADBEEF);
        chk("t2_size", bus.m_u_b_h_w, 3'b010); chk("t2_dstall", bus.d_stall, 1);
        cyc(); bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h0;
        #1; chk("t2_dvalid", bus.d_valid, 1); chk("t2_dstall_done", bus.d_stall, 0);
        chk("t2_istall", bus.i_stall, 1);
        cyc(); bus.m_rvalid = 0; bus.d_req = 0; bus.d_we = 0;
        #1; chk("t2_idle_m_req", bus.m_req, 0);
        cyc(); bus.m_gnt = 1;
        #1; chk("t2_i_m_req", bus.m_req, 1); chk("t2_i_addr", bus.m_addr, 32'h80);
        chk("t2_i_we", bus.m_we, 0);
        cyc(); bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h55;
        #1; chk("t2_ivalid", bus.i_valid, 1); chk("t2_irdata", bus.i_rdata, 32'h55);
        cyc(); bus.m_rvalid = 0; bus.i_req = 0;

        // 3: anti-starvation, 4 D grants then I
        cyc(); bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.i_req = 1; bus.i_addr = 32'hC0;
        for (int k = 0; k < 5; k++) begin
            #1; chk("t3_arb_m_req", bus.m_req, 0);
            cyc(); bus.m_gnt = 1;
            #1; chk("t3_grant_addr", bus.m_addr, (k < 4) ? 32'h200 : 32'hC0);
            cyc(); bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'(k);
            #1; chk("t3_done", {bus.d_valid, bus.i_valid}, (k < 4) ? 2'b10 : 2'b01);
            cyc(); bus.m_rvalid = 0;
        end
        cyc(); bus.m_gnt = 1;
        #1; chk("t3_d_after_i", bus.m_addr, 32'h200);
        cyc(); bus.m_gnt = 0; bus.m_rvalid = 1;
        cyc(); bus.m_rvalid = 0; bus.d_req = 0; bus.i_req = 0;

        // 4: flush in WAIT_I, drain, then new fetch
        cyc(); bus.i_req = 1; bus.i_addr = 32'h44;
        cyc(); bus.m_gnt = 1;
        #1; chk("t4_m_req", bus.m_req, 1);
        cyc(); bus.m_gnt = 0; bus.i_flush = 1;
        #1; chk("t4_flush_ivalid", bus.i_valid, 0);
        cyc(); bus.i_flush = 0; bus.i_addr = 32'h48;
        #1; chk("t4_drain_m_req", bus.m_req, 0);
        cyc();
        cyc(); bus.m_rvalid = 1; bus.m_rdata = 32'hAA;
        #1; chk("t4_drain_no_ivalid", bus.i_valid, 0);
        cyc(); bus.m_rvalid = 0;
        #1; chk("t4_idle_m_req", bus.m_req, 0);
        cyc(); bus.m_gnt = 1;
        #1; chk("t4_new_m_req", bus.m_req, 1); chk("t4_new_addr", bus.m_addr, 32'h48);
        cyc(); bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h77;
        #1; chk("t4_new_ivalid", bus.i_valid, 1); chk("t4_new_rdata", bus.i_rdata, 32'h77);
        cyc(); bus.m_rvalid = 0; bus.i_req = 0;

        // 4b: flush while still requesting keeps m_req, then drains
        cyc(); bus.i_req = 1; bus.i_addr = 32'h60;
        cyc(); bus.i_flush = 1; bus.i_req = 0;
        #1; chk("t4b_req_held", bus.m_req, 1);
        cyc(); bus.i_flush = 0; bus.m_gnt = 1;
        #1; chk("t4b_req_held2", bus.m_req, 1);
        cyc(); bus.m_gnt = 0; bus.m_rvalid = 1;
        #1; chk("t4b_no_ivalid", bus.i_valid, 0); chk("t4b_m_req", bus.m_req, 0);
        cyc(); bus.m_rvalid = 0;

        // 5: load timeout
        cyc(); bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        cyc(); bus.m_gnt = 1;
        cyc(); bus.m_gnt = 0;
        early = 1'b0;
        for (int n = 0; n < 255; n++) begin
            #1; if (bus.d_err || bus.d_valid) early = 1'b1;
            cyc();
        end
        #1; chk("t5_no_early", early, 0); chk("t5_derr", bus.d_err, 1);
        chk("t5_dvalid", bus.d_valid, 0); chk("t5_dstall", bus.d_stall, 0);
        cyc(); bus.d_req = 0;
        #1; chk("t5_derr_pulse", bus.d_err, 0); chk("t5_idle_m_req", bus.m_req, 0);

        // 6: asynchronous reset mid-transaction
        cyc(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h400; bus.d_wdata = 32'h1234;
        cyc();
        #1; chk("t6_req_before", bus.m_req, 1);
        #1; rst = 1'b1;
        #1; chk("t6_req_async", bus.m_req, 0);
        cyc(); rst = 1'b0;
        #1; chk("t6_idle_after", bus.m_req, 0);
        cyc(); bus.m_gnt = 1;
        #1; chk("t6_regrant", bus.m_req, 1); chk("t6_regrant_addr", bus.m_addr, 32'h400);
        cyc(); bus.m_gnt = 0;
        #1; bus.m_rvalid = 1;
        #1; chk("t6_dvalid_before", bus.d_valid, 1);
        #1; rst = 1'b1;
        #1; chk("t6_dvalid_async", bus.d_valid, 0); chk("t6_derr_async", bus.d_err, 0);
        cyc(); rst = 1'b0; bus.m_rvalid = 0; bus.d_req = 0; bus.d_we = 0;
        #1; chk("t6_final_m_req", bus.m_req, 0);
        chk("t6_final_addr", bus.m_addr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
